// File: rtl/rtx_pkg.sv
// Shared rtx constants used by the camera, scene-buffer, material-dictionary
// and UART command logic.
package rtx_pkg;

  localparam int          MAX_UART_DATA_BYTES = 48;
  localparam logic [7:0]  SYNC_BYTE           = 8'hA5;

endpackage : rtx_pkg

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/CMD/LEN/payload/CHK packets from a byte stream and publishes the
// command and payload of each packet whose XOR checksum matches.
module uart_cmd_parser
  import rtx_pkg::SYNC_BYTE;
#(
  parameter int MAX_UART_DATA_BYTES = rtx_pkg::MAX_UART_DATA_BYTES,
  parameter int TIMEOUT_CYCLES      = 100_000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             uart_rx_valid,
  input  logic [7:0]                       uart_rx_byte,
  output logic                             flash_active,
  output logic [7:0]                       flash_cmd,
  output logic [MAX_UART_DATA_BYTES*8-1:0] flash_data,
  output logic                             flash_wen,
  output logic                             err_pulse,
  output logic [7:0]                       err_count
);

  localparam int DATA_W = MAX_UART_DATA_BYTES * 8;
  localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHECK
  } state_e;

  state_e              state_q,       state_d;
  logic [7:0]          cmd_shadow_q,  cmd_shadow_d;
  logic [DATA_W-1:0]   data_shadow_q, data_shadow_d;
  logic [7:0]          len_q,         len_d;
  logic [7:0]          cnt_q,         cnt_d;
  logic [7:0]          xor_q,         xor_d;
  logic [GAP_W-1:0]    gap_q,         gap_d;
  logic [7:0]          flash_cmd_q,   flash_cmd_d;
  logic [DATA_W-1:0]   flash_data_q,  flash_data_d;
  logic                wen_q,         wen_d;
  logic                err_q,         err_d;
  logic [7:0]          err_cnt_q,     err_cnt_d;
  logic [GAP_W-1:0]    gap_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_shadow_q  <= '0;
      data_shadow_q <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      xor_q         <= '0;
      gap_q         <= '0;
      flash_cmd_q   <= '0;
      flash_data_q  <= '0;
      wen_q         <= 1'b0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_shadow_q  <= cmd_shadow_d;
      data_shadow_q <= data_shadow_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      xor_q         <= xor_d;
      gap_q         <= gap_d;
      flash_cmd_q   <= flash_cmd_d;
      flash_data_q  <= flash_data_d;
      wen_q         <= wen_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign gap_inc = gap_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    cmd_shadow_d  = cmd_shadow_q;
    data_shadow_d = data_shadow_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    xor_d         = xor_q;
    gap_d         = '0;
    flash_cmd_d   = flash_cmd_q;
    flash_data_d  = flash_data_q;
    wen_d         = 1'b0;
    err_d         = 1'b0;
    err_cnt_d     = err_cnt_q;

    if (uart_rx_valid) begin
      // A byte always restarts the gap count, so a byte on the expiry cycle wins.
      unique case (state_q)
        S_IDLE: begin
          if (uart_rx_byte == SYNC_BYTE) begin
            state_d       = S_CMD;
            data_shadow_d = '0;
            cnt_d         = '0;
            xor_d         = '0;
          end
        end
        S_CMD: begin
          cmd_shadow_d = uart_rx_byte;
          xor_d        = uart_rx_byte;
          state_d      = S_LEN;
        end
        S_LEN: begin
          len_d = uart_rx_byte;
          xor_d = xor_q ^ uart_rx_byte;
          if (uart_rx_byte == 8'd0) begin
            state_d = S_CHECK;
          end else if (int'(uart_rx_byte) <= MAX_UART_DATA_BYTES) begin
            state_d = S_PAYLOAD;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        S_PAYLOAD: begin
          for (int unsigned i = 0; i < MAX_UART_DATA_BYTES; i++) begin
            if (32'(cnt_q) == i) begin
              data_shadow_d[i*8 +: 8] = uart_rx_byte;
            end
          end
          xor_d = xor_q ^ uart_rx_byte;
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == len_q) begin
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (uart_rx_byte == xor_q) begin
            flash_cmd_d  = cmd_shadow_q;
            flash_data_d = data_shadow_q;
            wen_d        = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (gap_inc == GAP_W'(TIMEOUT_CYCLES)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        gap_d = gap_inc;
      end
    end

    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign flash_active = (state_q != S_IDLE);
  assign flash_cmd    = flash_cmd_q;
  assign flash_data   = flash_data_q;
  assign flash_wen    = wen_q;
  assign err_pulse    = err_q;
  assign err_count    = err_cnt_q;

endmodule : uart_cmd_parser

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: packet table, generated packets and
// hand-written timeout / reset / saturation sequences against a pulse scoreboard.
module tb_uart_cmd_parser;

  localparam int TO   = 20;
  localparam int MAXB = 48;
  localparam int DW   = MAXB * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [7:0]    rxb = 8'h00;
  logic          flash_active;
  logic [7:0]    flash_cmd;
  logic [DW-1:0] flash_data;
  logic          flash_wen;
  logic          err_pulse;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .MAX_UART_DATA_BYTES(MAXB),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx_valid(vld),
    .uart_rx_byte (rxb),
    .flash_active (flash_active),
    .flash_cmd    (flash_cmd),
    .flash_data   (flash_data),
    .flash_wen    (flash_wen),
    .err_pulse    (err_pulse),
    .err_count    (err_count)
  );

  typedef struct {
    logic          is_err;
    logic [7:0]    cmd;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    int          n;
    logic [63:0] b;
    logic        is_err;
    logic [7:0]  cmd;
    logic [63:0] data;
  } vec_t;

  exp_t          sb[$];
  vec_t          tbl[8];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [7:0]    m_cmd  = 8'h00;
  logic [DW-1:0] m_data = '0;
  int            m_errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic push_wen(input logic [7:0] c, input logic [DW-1:0] d);
    exp_t e;
    e.is_err = 1'b0; e.cmd = c; e.data = d;
    m_cmd = c; m_data = d;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.cmd = m_cmd; e.data = m_data;
    m_errs++;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] exp_cnt();
    return (m_errs > 255) ? 8'hFF : 8'(m_errs);
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    vld = 1'b1; rxb = b;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic send_vec(input int n, input logic [63:0] b);
    for (int i = 0; i < n; i++) send(b[(n-1-i)*8 +: 8]);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      #1;
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL pulse_wait: %0d expected pulses still pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Every flash_wen / err_pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (flash_wen || err_pulse)) begin
      chk("wen_err_exclusive", 64'(flash_wen & err_pulse), 64'd0);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got wen=%0b err=%0b, want none", flash_wen, err_pulse);
      end else begin
        n_cmp--;
        e = sb.pop_front();
        chk("pulse_is_err", 64'(err_pulse), 64'(e.is_err));
        chk("flash_cmd", 64'(flash_cmd), 64'(e.cmd));
        chk_data("flash_data", flash_data, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    chk_b;
    logic [DW-1:0] d;
    int            len;

    tbl[0] = '{6, 64'({8'hA5, 8'h00, 8'h02, 8'h34, 8'h12, 8'h24}), 1'b0, 8'h00, 64'h1234};
    tbl[1] = '{5, 64'({8'hA5, 8'h07, 8'h01, 8'h03, 8'h00}),        1'b1, 8'h00, 64'h0};
    tbl[2] = '{6, 64'({8'h00, 8'hFF, 8'hA5, 8'h06, 8'h00, 8'h06}), 1'b0, 8'h06, 64'h0};
    tbl[3] = '{5, 64'({8'hA5, 8'hA5, 8'h01, 8'hA5, 8'h01}),        1'b0, 8'hA5, 64'hA5};
    tbl[4] = '{3, 64'({8'hA5, 8'h05, 8'hFF}),                      1'b1, 8'h00, 64'h0};
    tbl[5] = '{3, 64'({8'hA5, 8'h01, 8'h31}),                      1'b1, 8'h00, 64'h0};
    tbl[6] = '{4, 64'({8'hA5, 8'h3C, 8'h00, 8'h3C}),               1'b0, 8'h3C, 64'h0};
    tbl[7] = '{7, 64'({8'hA5, 8'h11, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCF}), 1'b0, 8'h11, 64'hCCBBAA};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_active", 64'(flash_active), 64'd0);
    chk("rst_wen",    64'(flash_wen),    64'd0);
    chk("rst_err",    64'(err_pulse),    64'd0);
    chk("rst_cmd",    64'(flash_cmd),    64'd0);
    chk_data("rst_data", flash_data, '0);
    chk("rst_errcnt", 64'(err_count),    64'd0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      if (tbl[v].is_err) push_err();
      else push_wen(tbl[v].cmd, DW'(tbl[v].data));
      send_vec(tbl[v].n, tbl[v].b);
      drain();
      #1;
      chk("idle_after_pkt", 64'(flash_active), 64'd0);
      chk("err_count_tbl", 64'(err_count), 64'(exp_cnt()));
    end

    // Generated packets: full-size, single byte, random length, and a corrupted checksum.
    for (int k = 0; k < 4; k++) begin
      len = (k == 0) ? MAXB : (k == 1) ? 1 : $urandom_range(2, MAXB - 1);
      d = '0;
      chk_b = 8'(8'h40 + k) ^ 8'(len);
      for (int i = 0; i < len; i++) begin
        d[i*8 +: 8] = 8'($urandom_range(0, 255));
        chk_b ^= d[i*8 +: 8];
      end
      if (k == 3) begin
        chk_b = ~chk_b;
        push_err();
      end else begin
        push_wen(8'(8'h40 + k), d);
      end
      send(8'hA5);
      #1;
      chk("active_after_sync", 64'(flash_active), 64'd1);
      send(8'(8'h40 + k));
      send(8'(len));
      for (int i = 0; i < len; i++) send(d[i*8 +: 8]);
      send(chk_b);
      drain();
    end

    // Silence after CMD: err_pulse lands exactly TO cycles after the 0x06 byte.
    push_err();
    send(8'hA5);
    send(8'h06);
    repeat (TO - 1) @(negedge clk);
    #1;
    chk("timeout_early", 64'(err_pulse), 64'd0);
    @(negedge clk);
    #1;
    chk("timeout_pulse", 64'(err_pulse), 64'd1);
    chk("timeout_idle",  64'(flash_active), 64'd0);
    drain();
    push_wen(tbl[0].cmd, DW'(tbl[0].data));
    send_vec(tbl[0].n, tbl[0].b);
    drain();

    // A byte arriving on the expiry cycle is consumed instead of timing out.
    push_wen(8'h06, DW'(64'h55));
    send(8'hA5);
    send(8'h06);
    repeat (TO - 2) @(negedge clk);
    send(8'h01);
    send(8'h55);
    send(8'h52);
    drain();

    for (int k = 0; k < 256; k++) begin
      push_err();
      send_vec(3, 64'({8'hA5, 8'h05, 8'hFF}));
    end
    drain();
    #1;
    chk("err_count_sat", 64'(err_count), 64'hFF);

    // Mid-packet reset: abandoned silently, parsing restarts from IDLE.
    send_vec(3, 64'({8'hA5, 8'h03, 8'h01}));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_cmd = 8'h00; m_data = '0; m_errs = 0;
    #1;
    chk("mid_rst_active", 64'(flash_active), 64'd0);
    chk("mid_rst_cmd",    64'(flash_cmd),    64'd0);
    chk("mid_rst_errcnt", 64'(err_count),    64'd0);
    push_wen(8'h06, DW'(64'h10));
    send_vec(5, 64'({8'hA5, 8'h06, 8'h01, 8'h10, 8'h17}));
    drain();
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rst_errcnt_end", 64'(err_count), 64'd0);
    chk("final_cmd", 64'(flash_cmd), 64'h06);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_cmd_parser

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_UART_DATA_BYTES, default 48, meaning the maximum payload bytes per packet.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100_000, meaning the inter-byte gap (clk cycles) after which a partial packet is abandoned.
REQ-003 SHALL have port clk, input, 1, the single system clock (clk_rtx domain).
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port uart_rx_valid, input, 1, a one-cycle strobe marking a received byte.
REQ-006 SHALL have port uart_rx_byte, input, 8, the received byte, valid when uart_rx_valid is high.
REQ-007 SHALL have port flash_active, output, 1, high while a packet is in progress.
REQ-008 SHALL have port flash_cmd, output, 8, the command of the last good packet.
REQ-009 SHALL have port flash_data, output, MAX_UART_DATA_BYTES*8, the payload of the last good packet.
REQ-010 SHALL have port flash_wen, output, 1, a one-cycle pulse marking a good packet.
REQ-011 SHALL have port err_pulse, output, 1, a one-cycle pulse on any rejected packet.
REQ-012 SHALL have port err_count, output, 8, a saturating count of rejected packets.

Function
REQ-013 Packet format SHALL be: SYNC (0xA5), CMD, LEN, LEN payload bytes, CHK, where CHK = XOR of CMD, LEN and all payload bytes.
REQ-014 The FSM SHALL have states IDLE, CMD, LEN, PAYLOAD and CHECK, and SHALL advance only on cycles where uart_rx_valid is high.
REQ-015 IDLE transitions:
- SHALL go to CMD on byte 0xA5.
- SHALL silently discard any other byte, with no error.
REQ-016 CMD SHALL latch the byte as the shadow command and go to LEN.
REQ-017 LEN transitions:
- LEN = 0 SHALL go to CHECK.
- LEN ≤ MAX_UART_DATA_BYTES SHALL go to PAYLOAD.
- LEN > MAX SHALL go to IDLE and be treated as an error.
REQ-018 The shadow payload register SHALL be zeroed on entering CMD; payload byte i SHALL be stored at bits [8i+7:8i] (little-endian), with unused upper bits remaining zero.
REQ-019 PAYLOAD SHALL count received bytes and go to CHECK after exactly LEN bytes.
REQ-020 CHECK outcome:
- If the byte equals the running XOR, flash_cmd/flash_data SHALL be loaded from the shadow registers and flash_wen SHALL pulse on the next cycle.
- Otherwise err_pulse SHALL pulse on the next cycle.
- The FSM SHALL go to IDLE in either case.
REQ-021 flash_cmd and flash_data SHALL change only on a good packet and SHALL hold otherwise, including across errors and timeouts.
REQ-022 flash_active SHALL be high exactly when state ≠ IDLE (registered, same cycle as state).
REQ-023 Gap counter behaviour:
- A gap counter SHALL reset on every uart_rx_valid and increment each cycle while not in IDLE.
- On reaching TIMEOUT_CYCLES the FSM SHALL go to IDLE and err_pulse SHALL pulse.
- A byte arriving on the expiry cycle SHALL win: the byte is consumed and no timeout occurs.
REQ-024 err_count SHALL increment on each err_pulse and saturate at 255.
REQ-025 flash_wen and err_pulse SHALL never be high in the same cycle.
REQ-026 A 0xA5 byte received in a non-IDLE state SHALL be treated as data, with no resynchronisation.

Reset
REQ-027 Reset SHALL force:
- state IDLE;
- flash_active, flash_wen and err_pulse 0;
- flash_cmd 0 and flash_data 0;
- err_count 0;
- shadow registers, byte counter, running XOR and gap counter 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet without any flash_wen or err_pulse, and the first byte after reset release SHALL be parsed from IDLE.

Structure
REQ-029 MAX_UART_DATA_BYTES and the SYNC constant 0xA5 SHALL reside in the shared rtx package used by the camera, scene-buffer and material-dictionary logic.
REQ-030 The FSM state enum SHALL be local to the module.
REQ-031 The module SHALL be flat with no sub-modules; the gap counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-032 Camera packet test: bytes A5,00,02,34,12,24 SHALL produce flash_wen one cycle after the 0x24 byte, with flash_cmd = 0x00, flash_data[15:0] = 0x1234 and the upper bits 0.
REQ-033 Bad-checksum test: bytes A5,07,01,03,00 SHALL produce err_pulse, err_count = 1, no flash_wen, and the previous flash_cmd/flash_data unchanged.
REQ-034 Oversize test: bytes A5,05,FF with MAX = 48 SHALL produce err_pulse on the LEN byte, followed by a return to IDLE and flash_active = 0.
REQ-035 Timeout test: bytes A5,06 followed by silence SHALL produce err_pulse exactly TIMEOUT_CYCLES cycles after the 0x06 byte; a valid packet sent afterwards SHALL be accepted.
REQ-036 Mid-packet reset test: bytes A5,03,01, then a 1-cycle rst, then A5,06,01,10,17 SHALL produce a single flash_wen with flash_cmd = 0x06, flash_data = 0x10 and err_count = 0.
REQ-037 Noise test: bytes 00,FF,A5,06,00,06 SHALL produce flash_wen with flash_cmd = 0x06, flash_data = 0 and no err_pulse.
